node_text_emitter: RTL and testbench

Serializes a stream of 15-bit packed node names (three 5-bit letter codes) back into ASCII adjacency-list text, one character per cycle. Output lines have the form "aaa: bbb ccc\n". The block is the transmit-side counterpart of the character parser. It is used to dump node lists for debug and to generate parser test stimulus from known node streams.

---
 rtl/node_text_emitter_if.sv | 26 ++
 rtl/node_text_emitter.sv | 146 ++++++++++++++
 tb/tb_node_text_emitter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/node_text_emitter_if.sv
// Node-record in / ASCII-character out bundle for node_text_emitter.
// slave = emitter side, master = the block that feeds nodes and sinks characters.
interface node_text_emitter_if #(
    parameter int COUNT_W = 16
);
    logic               i_node_vld;
    logic [14:0]        i_node_str;
    logic               i_eol;
    logic               o_stall;
    logic               o_vld;
    logic [7:0]         o_char;
    logic               i_stall;
    logic               o_error;
    logic [COUNT_W-1:0] o_char_count;
    logic [COUNT_W-1:0] o_line_count;

    modport slave (
        input  i_node_vld, i_node_str, i_eol, i_stall,
        output o_stall, o_vld, o_char, o_error, o_char_count, o_line_count
    );

    modport master (
        output i_node_vld, i_node_str, i_eol, i_stall,
        input  o_stall, o_vld, o_char, o_error, o_char_count, o_line_count
    );
endinterface

// File: rtl/node_text_emitter.sv
// Turns packed 3-letter node records into "aaa: bbb ccc\n" text, one registered char per cycle.
// Latency 1 cycle; o_stall holds upstream until a record's last char transfers, i_stall freezes output.
module node_text_emitter #(
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    node_text_emitter_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_C0, S_C1, S_C2, S_COLON, S_NL
    } state_t;

    state_t             state_q, state_d;
    logic [14:0]        str_q, str_d;
    logic               eol_q, eol_d;
    logic               frec_q, frec_d;
    logic               first_q, first_d;
    logic               vld_q, vld_d;
    logic [7:0]         char_q, char_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] cc_q, cc_d;
    logic [COUNT_W-1:0] lc_q, lc_d;

    state_t             nxt_st;
    state_t             start_st;
    logic               xfer_out;
    logic               last_xfer;
    logic               stall;
    logic               xfer_in;
    logic               load;

    function automatic logic [7:0] letter(input logic [4:0] code);
        return (code > 5'd25) ? 8'h3F : (8'h61 + {3'b000, code});
    endfunction

    function automatic logic [7:0] char_of(input state_t s, input logic [14:0] str);
        case (s)
            S_PRE:   return 8'h20;
            S_C0:    return letter(str[14:10]);
            S_C1:    return letter(str[9:5]);
            S_C2:    return letter(str[4:0]);
            S_COLON: return 8'h3A;
            S_NL:    return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // S_IDLE as a result means the record has nothing left to print.
    function automatic state_t next_after(input state_t s, input logic frec, input logic eol);
        case (s)
            S_PRE:   return S_C0;
            S_C0:    return S_C1;
            S_C1:    return S_C2;
            S_C2:    return frec ? S_COLON : (eol ? S_NL : S_IDLE);
            S_COLON: return eol ? S_NL : S_IDLE;
            default: return S_IDLE;
        endcase
    endfunction

    assign xfer_out  = vld_q & ~bus.i_stall;
    assign nxt_st    = next_after(state_q, frec_q, eol_q);
    assign last_xfer = xfer_out & (nxt_st == S_IDLE);
    assign stall     = (state_q != S_IDLE) & ~last_xfer;
    assign xfer_in   = bus.i_node_vld & ~stall;

    always_comb begin
        state_d  = state_q;
        str_d    = str_q;
        eol_d    = eol_q;
        frec_d   = frec_q;
        first_d  = first_q;
        vld_d    = vld_q;
        char_d   = char_q;
        err_d    = err_q;
        cc_d     = cc_q;
        lc_d     = lc_q;
        load     = 1'b0;
        start_st = S_C0;

        if (xfer_out) begin
            cc_d = cc_q + 1'b1;
            if (state_q == S_NL) begin
                lc_d    = lc_q + 1'b1;
                first_d = 1'b1;
            end else if (last_xfer) begin
                first_d = 1'b0;
            end
            state_d = nxt_st;
            vld_d   = (nxt_st != S_IDLE);
            if (nxt_st != S_IDLE) begin
                char_d = char_of(nxt_st, str_q);
                load   = 1'b1;
            end
        end

        // Uses first_d so a record arriving on the cycle a '\n' leaves starts a new line.
        if (xfer_in) begin
            start_st = first_d ? S_C0 : S_PRE;
            str_d    = bus.i_node_str;
            eol_d    = bus.i_eol;
            frec_d   = first_d;
            state_d  = start_st;
            char_d   = char_of(start_st, bus.i_node_str);
            vld_d    = 1'b1;
            load     = 1'b1;
        end

        if (load && (char_d == 8'h3F)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            str_q   <= '0;
            eol_q   <= 1'b0;
            frec_q  <= 1'b0;
            first_q <= 1'b1;
            vld_q   <= 1'b0;
            char_q  <= '0;
            err_q   <= 1'b0;
            cc_q    <= '0;
            lc_q    <= '0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            eol_q   <= eol_d;
            frec_q  <= frec_d;
            first_q <= first_d;
            vld_q   <= vld_d;
            char_q  <= char_d;
            err_q   <= err_d;
            cc_q    <= cc_d;
            lc_q    <= lc_d;
        end
    end

    assign bus.o_stall      = stall;
    assign bus.o_vld        = vld_q;
    assign bus.o_char       = char_q;
    assign bus.o_error      = err_q;
    assign bus.o_char_count = cc_q;
    assign bus.o_line_count = lc_q;
endmodule

// File: tb/tb_node_text_emitter.sv
// Scoreboarded bench for node_text_emitter: table-driven records plus stall, error, reset and wrap sequences.
module tb_node_text_emitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    node_text_emitter_if #(.COUNT_W(16)) bus ();
    node_text_emitter_if #(.COUNT_W(4))  bw  ();

    node_text_emitter #(.COUNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    node_text_emitter #(.COUNT_W(4))  u_w   (.clk(clk), .rst(rst), .bus(bw.slave));

    // The narrow-counter instance sees exactly the same traffic as the main one.
    assign bw.i_node_vld = bus.i_node_vld;
    assign bw.i_node_str = bus.i_node_str;
    assign bw.i_eol      = bus.i_eol;
    assign bw.i_stall    = bus.i_stall;

    typedef struct {
        logic [4:0] c0, c1, c2;
        logic       eol;
        string      txt;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        bit         last;
    } exp_t;

    vec_t vecs [0:5];
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pops = 0;
    int   last_pop_cyc = 0;
    int   first_acc = 0;
    bit   mon_en = 1'b0;
    bit   stall_en = 1'b0;
    bit   prev_stalled = 1'b0;
    logic [7:0] prev_char = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 bus.i_stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit   xfer;
        bit   e_last;
        exp_t e;
        if (!mon_en) begin
            prev_stalled = 1'b0;
        end else begin
            xfer   = bus.o_vld && !bus.i_stall;
            e_last = 1'b0;
            if (prev_stalled) begin
                check("hold_vld", int'(bus.o_vld), 1);
                check("hold_char", int'(bus.o_char), int'(prev_char));
            end
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check("extra_char", int'(bus.o_char), -1);
                end else begin
                    e = exp_q.pop_front();
                    e_last = e.last;
                    check("char", int'(bus.o_char), int'(e.c));
                    if (e.c == 8'h3F) check("err_at_qmark", int'(bus.o_error), 1);
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            check("o_stall", int'(bus.o_stall), int'(bus.o_vld && !(xfer && e_last)));
            prev_stalled = bus.o_vld && bus.i_stall;
            prev_char    = bus.o_char;
        end
    end

    task automatic send(input vec_t v);
        bit stl;
        int n;
        for (int i = 0; i < v.txt.len(); i++) begin
            exp_q.push_back('{c: v.txt[i], last: (i == v.txt.len() - 1)});
        end
        bus.i_node_vld = 1'b1;
        bus.i_node_str = {v.c0, v.c1, v.c2};
        bus.i_eol      = v.eol;
        n = 0;
        do begin
            @(negedge clk);
            stl = bus.o_stall;
            @(posedge clk);
            #1;
            n++;
        end while (stl && n < 500);
        if (stl) check("accept_timeout", n, 0);
        bus.i_node_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.o_vld) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd18, 5'd21, 5'd17, 1'b0, "svr:"};
        vecs[1] = '{5'd5,  5'd5,  5'd19, 1'b0, " fft"};
        vecs[2] = '{5'd3,  5'd0,  5'd2,  1'b1, " dac\n"};
        vecs[3] = '{5'd14, 5'd20, 5'd19, 1'b1, "out:\n"};
        vecs[4] = '{5'd26, 5'd0,  5'd31, 1'b1, "?a?:\n"};
        vecs[5] = '{5'd0,  5'd0,  5'd0,  1'b1, "aaa:\n"};

        bus.i_node_vld = 1'b0;
        bus.i_node_str = '0;
        bus.i_eol      = 1'b0;
        bus.i_stall    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", int'(bus.o_vld), 0);
        check("rst_char", int'(bus.o_char), 0);
        check("rst_err", int'(bus.o_error), 0);
        check("rst_stall", int'(bus.o_stall), 0);
        check("rst_ccnt", int'(bus.o_char_count), 0);
        check("rst_lcnt", int'(bus.o_line_count), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Full line, no downstream stall: 13 chars with no bubble.
        for (int i = 0; i < 3; i++) begin
            send(vecs[i]);
            if (i == 0) first_acc = cyc;
        end
        drain();
        check("line_cycles", last_pop_cyc - first_acc, 12);
        check("line_ccnt", int'(bus.o_char_count), 13);
        check("line_lcnt", int'(bus.o_line_count), 1);

        send(vecs[3]);
        drain();
        check("single_stall", int'(bus.o_stall), 0);
        check("single_vld", int'(bus.o_vld), 0);
        check("single_ccnt", int'(bus.o_char_count), 18);

        stall_en = 1'b1;
        for (int i = 0; i < 3; i++) send(vecs[i]);
        drain();
        stall_en = 1'b0;
        check("stall_ccnt", int'(bus.o_char_count), 31);
        check("stall_lcnt", int'(bus.o_line_count), 3);
        check("pre_err", int'(bus.o_error), 0);

        send(vecs[4]);
        drain();
        send(vecs[3]);
        send(vecs[5]);
        drain();
        check("err_sticky", int'(bus.o_error), 1);

        // Reset after "svr: f" has gone out.
        pops = 0;
        send(vecs[0]);
        send(vecs[1]);
        while (pops < 6 && cyc < 5000) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_vld", int'(bus.o_vld), 0);
        check("mid_rst_ccnt", int'(bus.o_char_count), 0);
        check("mid_rst_lcnt", int'(bus.o_line_count), 0);
        check("mid_rst_err", int'(bus.o_error), 0);
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        send(vecs[5]);
        drain();
        check("post_rst_ccnt", int'(bus.o_char_count), 5);

        // Four 5-char lines: 20 chars wraps a 4-bit counter to 4.
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) send(vecs[3]);
        drain();
        check("wrap_wide_ccnt", int'(bus.o_char_count), 20);
        check("wrap_ccnt", int'(bw.o_char_count), 4);
        check("wrap_lcnt", int'(bw.o_line_count), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d expected=0", cyc);
        $fatal(1);
    end
endmodule
